pc_stack_seq: RTL and testbench

//  Parametrised program-counter sequencer for the CPU fetch stage. It supports increment,

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_stack_seq_if.sv | 29 ++
 rtl/pc_ret_stack.sv | 54 +++++
 rtl/pc_stack_seq.sv | 127 ++++++++++++
 tb/tb_pc_stack_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared opcode constants and the offset sign-extension helper for the PC sequencer.
package pc_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned SEXT_W = 64;

    localparam logic [OP_W-1:0] PC_HOLD = 3'b000;
    localparam logic [OP_W-1:0] PC_INC  = 3'b001;
    localparam logic [OP_W-1:0] PC_JMP  = 3'b010;
    localparam logic [OP_W-1:0] PC_REL  = 3'b011;
    localparam logic [OP_W-1:0] PC_CALL = 3'b100;
    localparam logic [OP_W-1:0] PC_RET  = 3'b101;
    localparam logic [OP_W-1:0] PC_BRC  = 3'b110;
    localparam logic [OP_W-1:0] PC_RSVD = 3'b111;

    // Sign-extend the low ofs_w bits of ofs to SEXT_W bits; caller truncates to ADDR_W.
    function automatic logic [SEXT_W-1:0] sext_ofs(input logic [SEXT_W-1:0] ofs,
                                                    input int unsigned      ofs_w);
        logic [SEXT_W-1:0] mask;
        mask = {SEXT_W{1'b1}} << ofs_w;
        if (ofs[6'(ofs_w - 1)]) begin
            return ofs | mask;
        end
        return ofs & ~mask;
    endfunction

endpackage

// File: rtl/pc_stack_seq_if.sv
// Control-unit / fetch-side bundle of the PC sequencer.
interface pc_stack_seq_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned OFS_W  = 8,
    parameter int unsigned RAS_D  = 4
);
    localparam int unsigned DEPTH_W = $clog2(RAS_D + 1);

    logic                en_in;
    logic [2:0]          pc_op;
    logic                cond;
    logic [OFS_W-1:0]    offset;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_out;
    logic [DEPTH_W-1:0]  ras_depth;
    logic                stk_err;
    logic                trap;

    modport master (
        output en_in, pc_op, cond, offset, target,
        input  pc_out, ras_depth, stk_err, trap
    );

    modport slave (
        input  en_in, pc_op, cond, offset, target,
        output pc_out, ras_depth, stk_err, trap
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: depth register is reset, entry storage is not; top entry read combinationally.
module pc_ret_stack #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [W-1:0]              din_i,
    output logic [W-1:0]              dout_o,
    output logic [$clog2(D+1)-1:0]    depth_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int unsigned DW = $clog2(D + 1);
    localparam int unsigned IW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    assign full_o  = (depth_q == DW'(D));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;
    assign dout_o  = mem_q[IW'(depth_q - DW'(1))];

    // Next depth; the parent never pushes when full or pops when empty.
    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // Depth register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry write at the current depth index.
    always_ff @(posedge clk) begin
        if (!rst && push_i && !full_o) begin
            mem_q[IW'(depth_q)] <= din_i;
        end
    end

endmodule

// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with return-address stack and sticky stack-fault flag.
// Build option: define PC_TRAP_EN to redirect faults to TRAP_VEC and pulse trap.
module pc_stack_seq
    import pc_pkg::*;
#(
    parameter int unsigned         ADDR_W  = 16,
    parameter int unsigned         OFS_W   = 8,
    parameter int unsigned         RAS_D   = 4,
    parameter logic [ADDR_W-1:0]   RST_VEC = '0
`ifdef PC_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0]   TRAP_VEC = ADDR_W'('h0010)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    pc_stack_seq_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(RAS_D + 1);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic               stk_err_q;
    logic               stk_err_d;
    logic [ADDR_W-1:0]  pc_inc_c;
    logic [ADDR_W-1:0]  pc_rel_c;
    logic               push_c;
    logic               pop_c;
    logic               fault_c;
    logic [ADDR_W-1:0]  ras_top_c;
    logic [DEPTH_W-1:0] ras_depth_c;
    logic               ras_full_c;
    logic               ras_empty_c;

    assign pc_inc_c = pc_q + ADDR_W'(1);
    assign pc_rel_c = pc_q + ADDR_W'(sext_ofs(SEXT_W'(bus.offset), OFS_W));

    pc_ret_stack #(
        .W (ADDR_W),
        .D (RAS_D)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   (pc_inc_c),
        .dout_o  (ras_top_c),
        .depth_o (ras_depth_c),
        .full_o  (ras_full_c),
        .empty_o (ras_empty_c)
    );

    // Next-PC mux, stack control and fault detection; nothing moves while en_in is low.
    always_comb begin
        pc_d    = pc_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        fault_c = 1'b0;
        if (bus.en_in) begin
            case (bus.pc_op)
                PC_INC:  pc_d = pc_inc_c;
                PC_JMP:  pc_d = bus.target;
                PC_REL:  pc_d = pc_rel_c;
                PC_CALL: begin
                    pc_d = bus.target;
                    if (ras_full_c) begin
                        fault_c = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
                PC_RET: begin
                    if (ras_empty_c) begin
                        fault_c = 1'b1;
                    end else begin
                        pop_c = 1'b1;
                        pc_d  = ras_top_c;
                    end
                end
                PC_BRC:  pc_d = bus.cond ? pc_rel_c : pc_inc_c;
                default: pc_d = pc_q;
            endcase
        end
`ifdef PC_TRAP_EN
        if (fault_c) begin
            pc_d = TRAP_VEC;
        end
`endif
        stk_err_d = stk_err_q | fault_c;
    end

    // PC and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RST_VEC;
            stk_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            stk_err_q <= stk_err_d;
        end
    end

`ifdef PC_TRAP_EN
    logic trap_q;
    logic trap_d;

    assign trap_d = fault_c;

    // Single-cycle trap pulse following a fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign bus.trap = trap_q;
`else
    assign bus.trap = 1'b0;
`endif

    assign bus.pc_out    = pc_q;
    assign bus.ras_depth = ras_depth_c;
    assign bus.stk_err   = stk_err_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Scoreboard bench for pc_stack_seq: driver queues expected state, monitor compares after each edge.
module tb_pc_stack_seq;
    import pc_pkg::*;

    logic clk;
    logic rst;

    pc_stack_seq_if #(.ADDR_W(16), .OFS_W(8), .RAS_D(4)) bus ();

    pc_stack_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_TRAP_EN
    localparam logic [15:0] OVF_PC = 16'h0010;
    localparam logic [15:0] UND_PC = 16'h0010;
    localparam logic        EXP_T  = 1'b1;
`else
    localparam logic [15:0] OVF_PC = 16'h5000;
    localparam logic [15:0] UND_PC = 16'h0000;
    localparam logic        EXP_T  = 1'b0;
`endif

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  depth;
        logic        err;
        logic        trap;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic r, input logic en, input logic [2:0] op, input logic c,
                        input logic [7:0] ofs, input logic [15:0] tgt,
                        input logic [15:0] e_pc, input logic [2:0] e_d, input logic e_err,
                        input logic e_trap, input string nm);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.en_in  = en;
        bus.pc_op  = op;
        bus.cond   = c;
        bus.offset = ofs;
        bus.target = tgt;
        e.pc = e_pc; e.depth = e_d; e.err = e_err; e.trap = e_trap; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one sample per edge, compared against the oldest queued expectation.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc",    32'(bus.pc_out),    32'(e.pc));
                chk(e.name, "depth", 32'(bus.ras_depth), 32'(e.depth));
                chk(e.name, "err",   32'(bus.stk_err),   32'(e.err));
                chk(e.name, "trap",  32'(bus.trap),      32'(e.trap));
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; bus.en_in = 1'b0; bus.pc_op = PC_HOLD; bus.cond = 1'b0;
        bus.offset = '0; bus.target = '0;

        // Reset (with an INC presented to show reset priority), then increments.
        step(1, 1, PC_INC,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "rst0");
        step(0, 1, PC_INC,  0, 8'h00, 16'h0000, 16'h0001, 0, 0, 0, "inc1");
        step(0, 1, PC_INC,  0, 8'h00, 16'h0000, 16'h0002, 0, 0, 0, "inc2");
        step(0, 1, PC_INC,  0, 8'h00, 16'h0000, 16'h0003, 0, 0, 0, "inc3");

        // Relative arithmetic and wrap-around.
        step(0, 1, PC_JMP,  0, 8'h00, 16'h0005, 16'h0005, 0, 0, 0, "jmp5");
        step(0, 1, PC_REL,  0, 8'hFD, 16'h0000, 16'h0002, 0, 0, 0, "rel_m3");
        step(0, 1, PC_JMP,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "jmp0");
        step(0, 1, PC_REL,  0, 8'hFF, 16'h0000, 16'hFFFF, 0, 0, 0, "rel_wrap");
        step(0, 1, PC_INC,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "inc_wrap");
        step(0, 1, PC_HOLD, 0, 8'h00, 16'h1234, 16'h0000, 0, 0, 0, "hold");
        step(0, 1, PC_RSVD, 0, 8'h00, 16'h1234, 16'h0000, 0, 0, 0, "rsvd");

        // Nested call / return.
        step(0, 1, PC_JMP,  0, 8'h00, 16'h0010, 16'h0010, 0, 0, 0, "jmp10");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h0100, 16'h0100, 1, 0, 0, "call1");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h0200, 16'h0200, 2, 0, 0, "call2");
        step(0, 1, PC_RET,  0, 8'h00, 16'h0000, 16'h0101, 1, 0, 0, "ret1");
        step(0, 1, PC_RET,  0, 8'h00, 16'h0000, 16'h0011, 0, 0, 0, "ret2");

        // Overflow on the fifth call; stack contents must survive it.
        step(0, 1, PC_CALL, 0, 8'h00, 16'h1000, 16'h1000, 1, 0, 0, "ovf_c1");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h2000, 16'h2000, 2, 0, 0, "ovf_c2");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h3000, 16'h3000, 3, 0, 0, "ovf_c3");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h4000, 16'h4000, 4, 0, 0, "ovf_c4");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h5000, OVF_PC,   4, 1, EXP_T, "ovf_c5");
        step(0, 1, PC_HOLD, 0, 8'h00, 16'h0000, OVF_PC,   4, 1, 0, "ovf_after");
        step(0, 1, PC_RET,  0, 8'h00, 16'h0000, 16'h3001, 3, 1, 0, "ovf_ret");
        step(1, 1, PC_CALL, 0, 8'h00, 16'h7777, 16'h0000, 0, 0, 0, "rst1");

        // Underflow gated by en_in, then a real underflow, then branches.
        step(0, 0, PC_RET,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "und_en0");
        step(0, 0, PC_INC,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "inc_en0");
        step(0, 1, PC_RET,  0, 8'h00, 16'h0000, UND_PC,   0, 1, EXP_T, "und");
        step(0, 1, PC_HOLD, 0, 8'h00, 16'h0000, UND_PC,   0, 1, 0, "und_after");
        step(0, 1, PC_BRC,  0, 8'h04, 16'h0000, UND_PC + 16'd1, 0, 1, 0, "brc_nt");
        step(0, 1, PC_BRC,  1, 8'h04, 16'h0000, UND_PC + 16'd5, 0, 1, 0, "brc_t");
        step(0, 1, PC_BRC,  1, 8'hFE, 16'h0000, UND_PC + 16'd3, 0, 1, 0, "brc_back");

        // Reset in the middle of a call sequence empties the stack.
        step(1, 0, PC_HOLD, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "rst2");
        step(0, 1, PC_JMP,  0, 8'h00, 16'h0300, 16'h0300, 0, 0, 0, "jmp300");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h0400, 16'h0400, 1, 0, 0, "mid_c1");
        step(0, 1, PC_CALL, 0, 8'h00, 16'h0500, 16'h0500, 2, 0, 0, "mid_c2");
        step(1, 1, PC_RET,  0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, "rst3");
        step(0, 1, PC_RET,  0, 8'h00, 16'h0000, UND_PC,   0, 1, EXP_T, "rst_und");
        step(0, 1, PC_INC,  0, 8'h00, 16'h0000, UND_PC + 16'd1, 0, 1, 0, "sticky");

        @(negedge clk);
        bus.en_in = 1'b0;
        rst       = 1'b0;

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
